pci_target_ctrl_gen: RTL and testbench
======================================

PCI_TARGET_CTRL_GEN -- requirements
Module: pci_target_ctrl_gen

Interface
REQ-001 Parameter DATA_W, default 32: width of ad.
REQ-002 Parameter ADDR_W, default 4: local word-address width; target memory holds 2^ADDR_W words.
REQ-003 Parameter BASE_ADDR, default 0: value matched against ad[DATA_W-1:ADDR_W+2] for decode.
REQ-004 Parameter LINE_WORDS, default 4: cacheline-wrap burst length; power of 2, at most 2^ADDR_W.
REQ-005 Parameter WAIT_CYCLES, default 1: initial target wait states before first TRDY, range 1..7.
REQ-006 clk  input  1  single clock; all logic on rising edge.
REQ-007 rst  input  1  synchronous, active-low reset.
REQ-008 frame  input  1  PCI FRAME#, active-low.
REQ-009 IRDY  input  1  PCI IRDY#, active-low.
REQ-010 ad  input  DATA_W  address/data bus, sampled in the address phase.
REQ-011 cmd  input  4  C/BE# command, sampled in the address phase.
REQ-012 Parity_check  input  1  1 = parity good for the current data phase.
REQ-013 TRDY  output  1  PCI TRDY#, active-low.
REQ-014 DEVSEL  output  1  PCI DEVSEL#, active-low.
REQ-015 stop  output  1  PCI STOP#, active-low.
REQ-016 EnableWrite  output  1  memory write strobe, active-high.
REQ-017 signal_to_buf  output  1  1 = drive read data onto ad.
REQ-018 add_2_mem  output  ADDR_W  current memory word address.
REQ-019 perr  output  1  PCI PERR#, active-low.

Function
REQ-020 States: IDLE, WAIT, DATA, DISC, TURN; state, counters and address registered.
REQ-021 Claim: in IDLE with frame=0, cmd in {0110, 0111, 1100, 1110, 1111} and BASE_ADDR match, the block latches add_2_mem=ad[ADDR_W+1:2], burst mode=ad[1:0] and cmd, then enters WAIT; otherwise it stays in IDLE with all outputs inactive.
REQ-022 DEVSEL goes to 0 on the edge that leaves IDLE and stays 0 until TURN.
REQ-023 WAIT lasts exactly WAIT_CYCLES cycles, then DATA; TRDY=1 in WAIT.
REQ-024 In DATA, TRDY=0; a transfer occurs in any cycle where IRDY=0 and TRDY=0; if IRDY=1, the state and address hold.
REQ-025 Read cmds (0110, 1100, 1110): signal_to_buf=1 in WAIT, DATA and DISC, and 0 otherwise.
REQ-026 Write cmds (0111, 1111): EnableWrite=1 combinationally only in transfer cycles, with add_2_mem valid in the same cycle.
REQ-027 Address advance after each transfer, mode 00 (linear): add_2_mem+1.
REQ-028 Address advance after each transfer, mode 10 (cacheline wrap): the low log2(LINE_WORDS) bits increment modulo LINE_WORDS and the upper bits hold.
REQ-029 Modes 01 and 11 are reserved: the block disconnects (enters DISC) after the first transfer.
REQ-030 A transfer with frame=1 is the last data phase: next state is TURN.
REQ-031 A transfer at add_2_mem=2^ADDR_W-1 in linear mode with frame=0 leads to DISC; add_2_mem does not wrap.
REQ-032 DISC: stop=0, TRDY=1, DEVSEL=0, and no transfers; the block stays in DISC until frame=1, then enters TURN.
REQ-033 When REQ-029/REQ-031 coincide with REQ-030 (frame=1), TURN takes priority.
REQ-034 TURN lasts one cycle: TRDY, DEVSEL and stop are 1, signal_to_buf=0; then IDLE.
REQ-035 A new frame=0 seen during TURN is not claimed; decode happens only in IDLE.

Reset
REQ-036 rst=0 at a clock edge forces IDLE, TRDY=1, DEVSEL=1, stop=1, perr=1, EnableWrite=0, signal_to_buf=0, add_2_mem=0, and clears the wait counter.
REQ-037 Reset mid-burst aborts the burst with no further EnableWrite pulse; after release, the block waits in IDLE for a new address phase.

Configuration
REQ-038 Macro PCI_PARITY_CHECK_EN, when defined: a write transfer with Parity_check=0 suppresses EnableWrite for that cycle and drives perr=0 for exactly the next cycle; the burst continues.
REQ-039 Without PCI_PARITY_CHECK_EN: Parity_check is ignored and perr is held at 1.

Verification
REQ-040 Write burst: BASE_ADDR=0, ad=0x8 mode 00, cmd=0111, WAIT_CYCLES=1, IRDY=0, 3 transfers, frame=1 on the 3rd -> EnableWrite pulses at add_2_mem 2, 3, 4, then TURN, then IDLE.
REQ-041 Cacheline read: ad=0x3A (word 14, mode 10), cmd=1110, LINE_WORDS=4, 4 transfers -> add_2_mem sequence 14, 15, 12, 13, with signal_to_buf=1 throughout.
REQ-042 End-of-memory disconnect: linear read starting at word 15 with frame held 0 -> one transfer, then stop=0 with TRDY=1 until frame=1, then TURN.
REQ-043 Miss: ad[31:6]=1 with BASE_ADDR=0 -> DEVSEL stays 1 and the state stays IDLE.
REQ-044 IRDY wait plus reset: IRDY=1 for 2 cycles in DATA -> address holds; then rst=0 mid-burst -> all outputs reach their reset values at the next edge.
REQ-045 With PCI_PARITY_CHECK_EN: Parity_check=0 on the 2nd write transfer -> no EnableWrite on that transfer, perr=0 for one cycle, and the 3rd transfer is written normally.

Source files
------------

// File: rtl/pci_target_ctrl_gen.sv
// pci_target_ctrl_gen
// PCI target-side transaction controller for a small local word memory.
// Decodes an address phase against BASE_ADDR, inserts WAIT_CYCLES initial
// wait states, then runs linear or cacheline-wrap bursts. It disconnects
// at the end of memory or on a reserved burst mode, and runs one turnaround
// cycle before returning to idle.
// Optional feature: define PCI_PARITY_CHECK_EN to block writes that carry
// bad parity and to report them on perr.
module pci_target_ctrl_gen #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 4,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          LINE_WORDS  = 4,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame,
    input  logic              IRDY,
    input  logic [DATA_W-1:0] ad,
    input  logic [3:0]        cmd,
    input  logic              Parity_check,
    output logic              TRDY,
    output logic              DEVSEL,
    output logic              stop,
    output logic              EnableWrite,
    output logic              signal_to_buf,
    output logic [ADDR_W-1:0] add_2_mem,
    output logic              perr
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_DISC = 3'd3;
    localparam logic [2:0] ST_TURN = 3'd4;

    localparam int              TAG_W     = DATA_W - ADDR_W - 2;
    localparam logic [TAG_W-1:0] BASE_TAG = TAG_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(LINE_WORDS - 1);
    localparam logic [2:0]        WAIT_LAST = 3'(WAIT_CYCLES - 1);

    // Read commands: memory read, memory read multiple, memory read line.
    function automatic logic cmd_is_read(input logic [3:0] c);
        logic r;
        case (c)
            4'b0110: r = 1'b1;
            4'b1100: r = 1'b1;
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Write commands: memory write, memory write and invalidate.
    function automatic logic cmd_is_write(input logic [3:0] c);
        logic w;
        case (c)
            4'b0111: w = 1'b1;
            4'b1111: w = 1'b1;
            default: w = 1'b0;
        endcase
        return w;
    endfunction

    // Address after a transfer. Linear mode saturates at the top of memory
    // (the burst disconnects there). Wrap mode cycles inside the cacheline.
    // Reserved modes hold the address.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [1:0]        m);
        logic [ADDR_W-1:0] n;
        logic [ADDR_W-1:0] inc;
        inc = a + {{(ADDR_W-1){1'b0}}, 1'b1};
        case (m)
            2'b00: begin
                if (a == ADDR_MAX) begin
                    n = a;
                end else begin
                    n = inc;
                end
            end
            2'b10:   n = (a & ~LINE_MASK) | (inc & LINE_MASK);
            default: n = a;
        endcase
        return n;
    endfunction

    logic [2:0]        state_r;
    logic [2:0]        state_nx_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_nx_s;
    logic [2:0]        wait_cnt_r;
    logic [2:0]        wait_cnt_nx_s;
    logic [1:0]        mode_r;
    logic              read_r;
    logic              write_r;
    logic              read_nx_s;
    logic              trdy_r;
    logic              devsel_r;
    logic              stop_r;
    logic              buf_r;
    logic              perr_r;
    logic              hit_s;
    logic              claim_s;
    logic              transfer_s;
    logic              wr_xfer_s;
    logic              parity_ok_s;
    logic              active_nx_s;

    assign hit_s      = (ad[DATA_W-1:ADDR_W+2] == BASE_TAG) &&
                        (cmd_is_read(cmd) || cmd_is_write(cmd));
    assign claim_s    = (state_r == ST_IDLE) && !frame && hit_s;
    // Reset is folded in so that no write strobe fires in the cycle a reset is applied.
    assign transfer_s = rst && (state_r == ST_DATA) && !IRDY;
    assign wr_xfer_s  = transfer_s && write_r;

`ifdef PCI_PARITY_CHECK_EN
    assign parity_ok_s = Parity_check;
`else
    logic unused_parity_s;
    assign unused_parity_s = Parity_check;
    assign parity_ok_s     = 1'b1;
`endif

    assign EnableWrite   = wr_xfer_s && parity_ok_s;
    assign TRDY          = trdy_r;
    assign DEVSEL        = devsel_r;
    assign stop          = stop_r;
    assign signal_to_buf = buf_r;
    assign add_2_mem     = addr_r;
    assign perr          = perr_r;

    // Next-state, next-address and wait-counter logic for the target FSM.
    always_comb begin
        state_nx_s    = state_r;
        addr_nx_s     = addr_r;
        wait_cnt_nx_s = wait_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (claim_s) begin
                    state_nx_s    = ST_WAIT;
                    addr_nx_s     = ad[ADDR_W+1:2];
                    wait_cnt_nx_s = 3'd0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == WAIT_LAST) begin
                    state_nx_s    = ST_DATA;
                    wait_cnt_nx_s = 3'd0;
                end else begin
                    wait_cnt_nx_s = wait_cnt_r + 3'd1;
                end
            end
            ST_DATA: begin
                if (transfer_s) begin
                    addr_nx_s = next_addr(addr_r, mode_r);
                    if (frame) begin
                        state_nx_s = ST_TURN;
                    end else if (mode_r[0]) begin
                        state_nx_s = ST_DISC;
                    end else if ((mode_r == 2'b00) && (addr_r == ADDR_MAX)) begin
                        state_nx_s = ST_DISC;
                    end else begin
                        state_nx_s = ST_DATA;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_DISC: begin
                if (frame) begin
                    state_nx_s = ST_TURN;
                end else begin
                    state_nx_s = ST_DISC;
                end
            end
            ST_TURN: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Read/write direction of the transaction that the next cycle belongs to.
    always_comb begin
        if (claim_s) begin
            read_nx_s = cmd_is_read(cmd);
        end else begin
            read_nx_s = read_r;
        end
        active_nx_s = (state_nx_s == ST_WAIT) || (state_nx_s == ST_DATA) ||
                      (state_nx_s == ST_DISC);
    end

    // State, address, transaction attributes and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            addr_r     <= '0;
            wait_cnt_r <= 3'd0;
            mode_r     <= 2'b00;
            read_r     <= 1'b0;
            write_r    <= 1'b0;
            trdy_r     <= 1'b1;
            devsel_r   <= 1'b1;
            stop_r     <= 1'b1;
            buf_r      <= 1'b0;
            perr_r     <= 1'b1;
        end else begin
            state_r    <= state_nx_s;
            addr_r     <= addr_nx_s;
            wait_cnt_r <= wait_cnt_nx_s;
            if (claim_s) begin
                mode_r  <= ad[1:0];
                read_r  <= cmd_is_read(cmd);
                write_r <= cmd_is_write(cmd);
            end
            trdy_r   <= (state_nx_s != ST_DATA);
            devsel_r <= !active_nx_s;
            stop_r   <= (state_nx_s != ST_DISC);
            buf_r    <= active_nx_s && read_nx_s;
            // A write that is blocked for bad parity is reported for exactly one cycle.
            perr_r   <= !(wr_xfer_s && !parity_ok_s);
        end
    end

endmodule

// File: tb/tb_pci_target_ctrl_gen.sv
// Directed self-checking bench for pci_target_ctrl_gen (default parameters).
module tb_pci_target_ctrl_gen;

    logic        clk;
    logic        rst;
    logic        frame;
    logic        IRDY;
    logic [31:0] ad;
    logic [3:0]  cmd;
    logic        Parity_check;
    logic        TRDY;
    logic        DEVSEL;
    logic        stop;
    logic        EnableWrite;
    logic        signal_to_buf;
    logic [3:0]  add_2_mem;
    logic        perr;

    int checks = 0;
    int errors = 0;

    pci_target_ctrl_gen dut (
        .clk          (clk),
        .rst          (rst),
        .frame        (frame),
        .IRDY         (IRDY),
        .ad           (ad),
        .cmd          (cmd),
        .Parity_check (Parity_check),
        .TRDY         (TRDY),
        .DEVSEL       (DEVSEL),
        .stop         (stop),
        .EnableWrite  (EnableWrite),
        .signal_to_buf(signal_to_buf),
        .add_2_mem    (add_2_mem),
        .perr         (perr)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Bus control outputs packed as {TRDY, DEVSEL, stop, signal_to_buf}.
    task automatic check_ctl(input string tag, input logic [3:0] exp);
        check_val(tag, {28'd0, TRDY, DEVSEL, stop, signal_to_buf}, {28'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; frame = 1'b1; IRDY = 1'b1;
        ad = 32'h0; cmd = 4'h0; Parity_check = 1'b1;
        step(); step();

        // Reset state
        check_ctl("rst_ctl", 4'b1110);
        check_val("rst_addr", add_2_mem, 32'd0);
        check_val("rst_perr", perr, 32'd1);
        check_val("rst_ew", EnableWrite, 32'd0);

        // Linear write burst at word 2, three transfers
        rst = 1'b1; step();
        frame = 1'b0; ad = 32'h8; cmd = 4'b0111; #1;
        check_ctl("wr_idle_ctl", 4'b1110);
        step();
        ad = 32'hDEAD_0001; IRDY = 1'b0; #1;
        check_ctl("wr_wait_ctl", 4'b1010);
        check_val("wr_wait_addr", add_2_mem, 32'd2);
        check_val("wr_wait_ew", EnableWrite, 32'd0);
        step();
        check_ctl("wr_data_ctl", 4'b0010);
        check_val("wr_x1_ew", EnableWrite, 32'd1);
        check_val("wr_x1_addr", add_2_mem, 32'd2);
        step();
        check_val("wr_x2_ew", EnableWrite, 32'd1);
        check_val("wr_x2_addr", add_2_mem, 32'd3);
        step();
        frame = 1'b1; #1;
        check_val("wr_x3_ew", EnableWrite, 32'd1);
        check_val("wr_x3_addr", add_2_mem, 32'd4);
        step();
        IRDY = 1'b1; #1;
        check_ctl("wr_turn_ctl", 4'b1110);
        check_val("wr_turn_ew", EnableWrite, 32'd0);
        step();
        check_ctl("wr_idle2_ctl", 4'b1110);

        // Cacheline-wrap read from word 14
        frame = 1'b0; ad = 32'h3A; cmd = 4'b1110;
        step();
        IRDY = 1'b0; #1;
        check_ctl("cl_wait_ctl", 4'b1011);
        check_val("cl_wait_addr", add_2_mem, 32'd14);
        step();
        check_ctl("cl_data_ctl", 4'b0011);
        check_val("cl_x1_addr", add_2_mem, 32'd14);
        check_val("cl_x1_ew", EnableWrite, 32'd0);
        step();
        check_val("cl_x2_addr", add_2_mem, 32'd15);
        step();
        check_val("cl_x3_addr", add_2_mem, 32'd12);
        check_ctl("cl_x3_ctl", 4'b0011);
        step();
        frame = 1'b1; #1;
        check_val("cl_x4_addr", add_2_mem, 32'd13);
        step();
        // Matching address phase during TURN must be ignored
        frame = 1'b0; ad = 32'h0; cmd = 4'b0110; IRDY = 1'b1; #1;
        check_ctl("cl_turn_ctl", 4'b1110);
        step();
        frame = 1'b1; #1;
        check_ctl("turn_noclaim_ctl", 4'b1110);
        step();

        // End-of-memory disconnect: linear read at word 15
        frame = 1'b0; ad = 32'h3C; cmd = 4'b0110;
        step();
        IRDY = 1'b0;
        step();
        check_ctl("eom_data_ctl", 4'b0011);
        check_val("eom_x1_addr", add_2_mem, 32'd15);
        step();
        check_ctl("eom_disc_ctl", 4'b1001);
        check_val("eom_disc_addr", add_2_mem, 32'd15);
        step();
        check_ctl("eom_disc2_ctl", 4'b1001);
        frame = 1'b1; IRDY = 1'b1;
        step();
        check_ctl("eom_turn_ctl", 4'b1110);
        step();

        // Reserved mode 01 write: one transfer then disconnect
        frame = 1'b0; ad = 32'h09; cmd = 4'b0111;
        step();
        IRDY = 1'b0;
        step();
        check_val("rsv_x1_ew", EnableWrite, 32'd1);
        check_val("rsv_x1_addr", add_2_mem, 32'd2);
        step();
        check_ctl("rsv_disc_ctl", 4'b1000);
        check_val("rsv_disc_ew", EnableWrite, 32'd0);
        frame = 1'b1; IRDY = 1'b1;
        step(); step();

        // End-of-memory transfer that is also the last data phase -> TURN
        frame = 1'b0; ad = 32'h3C; cmd = 4'b1100;
        step();
        IRDY = 1'b0;
        step();
        frame = 1'b1;
        step();
        check_ctl("prio_turn_ctl", 4'b1110);
        IRDY = 1'b1;
        step();

        // Address miss and unsupported command
        frame = 1'b0; ad = 32'h40; cmd = 4'b0111;
        step();
        check_ctl("miss1_ctl", 4'b1110);
        step();
        check_ctl("miss2_ctl", 4'b1110);
        ad = 32'h0; cmd = 4'b0010;
        step();
        check_ctl("badcmd_ctl", 4'b1110);
        frame = 1'b1;
        step();

        // IRDY wait states then reset mid-burst
        frame = 1'b0; ad = 32'h0; cmd = 4'b0111;
        step(); step();
        check_ctl("iw_data_ctl", 4'b0010);
        check_val("iw_hold1_ew", EnableWrite, 32'd0);
        check_val("iw_hold1_addr", add_2_mem, 32'd0);
        step();
        check_val("iw_hold2_addr", add_2_mem, 32'd0);
        check_ctl("iw_hold2_ctl", 4'b0010);
        step();
        IRDY = 1'b0; #1;
        check_val("iw_x1_ew", EnableWrite, 32'd1);
        step();
        rst = 1'b0; #1;
        check_val("iw_x2_addr", add_2_mem, 32'd1);
        check_val("iw_rst_ew", EnableWrite, 32'd0);
        step();
        check_ctl("iw_rst_ctl", 4'b1110);
        check_val("iw_rst_addr", add_2_mem, 32'd0);
        check_val("iw_rst_perr", perr, 32'd1);
        rst = 1'b1; frame = 1'b1; IRDY = 1'b1;
        step();
        check_ctl("iw_post_ctl", 4'b1110);
        check_val("iw_post_ew", EnableWrite, 32'd0);

        // Bad parity on the 2nd write transfer
        frame = 1'b0; ad = 32'h10; cmd = 4'b0111;
        step();
        IRDY = 1'b0;
        step();
        check_val("par_x1_ew", EnableWrite, 32'd1);
        check_val("par_x1_addr", add_2_mem, 32'd4);
        step();
        Parity_check = 1'b0; #1;
        check_val("par_x2_addr", add_2_mem, 32'd5);
`ifdef PCI_PARITY_CHECK_EN
        check_val("par_x2_ew", EnableWrite, 32'd0);
`else
        check_val("par_x2_ew", EnableWrite, 32'd1);
`endif
        step();
        Parity_check = 1'b1; frame = 1'b1; #1;
`ifdef PCI_PARITY_CHECK_EN
        check_val("par_perr", perr, 32'd0);
`else
        check_val("par_perr", perr, 32'd1);
`endif
        check_val("par_x3_ew", EnableWrite, 32'd1);
        check_val("par_x3_addr", add_2_mem, 32'd6);
        step();
        IRDY = 1'b1; #1;
        check_val("par_perr_clr", perr, 32'd1);
        check_ctl("par_turn_ctl", 4'b1110);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
